// File: rtl/dmem_wait_ctrl.sv
// rtl/dmem_wait_ctrl.sv - data memory with request/ready handshake, wait states, byte lanes and fault reporting
module dmem_wait_ctrl #(
    parameter int R_g   = 256,
    parameter int C_g   = 32,
    parameter int LAT_g = 2
) (
    input  logic               DMW_IN_CLK,
    input  logic               DMW_IN_RST,
    input  logic               DMW_IN_REQ,
    input  logic               DMW_IN_WE,
    input  logic [C_g/8-1:0]   DMW_IN_BE,
    input  logic [31:0]        DMW_IN_ADDR,
    input  logic [C_g-1:0]     DMW_IN_W_DATA,
    output logic [C_g-1:0]     DMW_OUT_R_DATA,
    output logic               DMW_OUT_READY,
    output logic               DMW_OUT_ERR,
    output logic               DMW_OUT_BUSY
);

    localparam int NB = C_g / 8;
    localparam int AW = (NB > 1) ? $clog2(NB) : 0;
    localparam int IW = (R_g > 1) ? $clog2(R_g) : 1;
    localparam logic [3:0] LAT_M1 = (LAT_g > 0) ? 4'(LAT_g - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_next;
    logic [3:0] cnt;
    logic [3:0] cnt_next;
    logic accept;
    logic enter_resp;

    // Memory array; deliberately not cleared by reset
    logic [C_g-1:0] mem [R_g];

    // Request decode on the live inputs
    logic [31:0] in_word;
    logic        in_misal;
    logic        in_oor;
    logic        in_fault;

    assign in_word  = DMW_IN_ADDR >> AW;
    assign in_misal = (DMW_IN_ADDR & 32'(NB - 1)) != 32'd0;
    assign in_oor   = in_word >= 32'(R_g);
    assign in_fault = in_misal | in_oor;

    // Access captured at acceptance, held through the wait states
    logic           we_q;
    logic [NB-1:0]  be_q;
    logic [IW-1:0]  idx_q;
    logic [C_g-1:0] wdata_q;
    logic           fault_q;
    logic           err_q;

    // Operands of the access committing this cycle: with zero wait states the
    // commit happens on the accepting edge, so the live inputs are used directly
    logic           op_we;
    logic [NB-1:0]  op_be;
    logic [IW-1:0]  op_idx;
    logic [C_g-1:0] op_wdata;
    logic           op_fault;

    assign op_we    = accept ? DMW_IN_WE           : we_q;
    assign op_be    = accept ? DMW_IN_BE           : be_q;
    assign op_idx   = accept ? in_word[IW-1:0]     : idx_q;
    assign op_wdata = accept ? DMW_IN_W_DATA       : wdata_q;
    assign op_fault = accept ? in_fault            : fault_q;

    // Next-state logic: acceptance from IDLE/RESP, countdown in WAIT
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        enter_resp = 1'b0;
        case (state)
            S_IDLE, S_RESP: begin
                state_next = S_IDLE;
                if (DMW_IN_REQ) begin
                    accept = 1'b1;
                    if (LAT_g == 0) begin
                        state_next = S_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_next = S_WAIT;
                        cnt_next   = LAT_M1;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    state_next = S_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge DMW_IN_CLK) begin
        if (DMW_IN_RST) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Capture the request so later input changes are ignored
    always_ff @(posedge DMW_IN_CLK) begin
        if (DMW_IN_RST) begin
            we_q    <= 1'b0;
            be_q    <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            fault_q <= 1'b0;
        end else if (accept) begin
            we_q    <= DMW_IN_WE;
            be_q    <= DMW_IN_BE;
            idx_q   <= in_word[IW-1:0];
            wdata_q <= DMW_IN_W_DATA;
            fault_q <= in_fault;
        end
    end

    // Byte-lane write on the edge entering RESP; faults and reset suppress it
    always_ff @(posedge DMW_IN_CLK) begin
        if (!DMW_IN_RST && enter_resp && op_we && !op_fault) begin
            for (int i = 0; i < NB; i++) begin
                if (op_be[i]) begin
                    mem[op_idx][i*8 +: 8] <= op_wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read data and fault status, updated on the edge entering RESP
    always_ff @(posedge DMW_IN_CLK) begin
        if (DMW_IN_RST) begin
            DMW_OUT_R_DATA <= '0;
            err_q          <= 1'b0;
        end else if (enter_resp) begin
            err_q <= op_fault;
            if (!op_we && !op_fault) begin
                DMW_OUT_R_DATA <= mem[op_idx];
            end
        end
    end

    assign DMW_OUT_READY = (state == S_RESP);
    assign DMW_OUT_BUSY  = (state == S_WAIT);
    assign DMW_OUT_ERR   = DMW_OUT_READY & err_q;

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb/tb_dmem_wait_ctrl.sv - scoreboard bench for dmem_wait_ctrl with a word-level reference model
module tb_dmem_wait_ctrl;

    localparam int LAT = 2;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    dmem_wait_ctrl #(.R_g(256), .C_g(32), .LAT_g(LAT)) dut (
        .DMW_IN_CLK    (clk),
        .DMW_IN_RST    (rst),
        .DMW_IN_REQ    (req),
        .DMW_IN_WE     (we),
        .DMW_IN_BE     (be),
        .DMW_IN_ADDR   (addr),
        .DMW_IN_W_DATA (wdata),
        .DMW_OUT_R_DATA(rdata),
        .DMW_OUT_READY (ready),
        .DMW_OUT_ERR   (err),
        .DMW_OUT_BUSY  (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int          edge_no;
        logic        err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          tests = 0;
    int          fails = 0;
    int          edges = 0;
    int          busy_lo = 1;
    int          busy_hi = 0;
    bit          mon_en = 1'b0;
    logic [31:0] m_mem [256];
    logic [31:0] m_rd = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, exp, edges);
        end
    endtask

    // Monitor: counts edges, checks BUSY window, ERR gating and pops the scoreboard on READY
    always @(negedge clk) begin
        exp_t e;
        edges = edges + 1;
        if (mon_en) begin
            chk("busy", {31'd0, busy}, {31'd0, (edges >= busy_lo) && (edges <= busy_hi)});
            if (ready === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_ready", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("ready_latency", 32'(edges), 32'(e.edge_no));
                    chk("err", {31'd0, err}, {31'd0, e.err});
                    chk("rdata", rdata, e.rdata);
                end
            end else begin
                chk("err_without_ready", {31'd0, err}, 32'd0);
                if (sb.size() > 0 && sb[0].edge_no < edges) begin
                    e = sb.pop_front();
                    chk("missing_ready", 32'd0, 32'd1);
                end
            end
        end
    end

    task automatic junk();
        req   = 1'($urandom);
        we    = 1'($urandom);
        be    = 4'($urandom);
        addr  = $urandom;
        wdata = $urandom;
    endtask

    // Issue one access; gap = idle cycles after completion (0 keeps back-to-back)
    task automatic issue(input logic w, input logic [3:0] b, input logic [31:0] a,
                         input logic [31:0] d, input int gap);
        int   k;
        logic fault;
        @(negedge clk);
        req = 1'b1; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        k = edges + 1;
        fault = (a % 4 != 0) || (a >= 32'd1024);
        if (!fault) begin
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) m_mem[a / 4][i*8 +: 8] = d[i*8 +: 8];
            end else begin
                m_rd = m_mem[a / 4];
            end
        end
        sb.push_back('{edge_no: k + LAT, err: fault, rdata: m_rd});
        busy_lo = k;
        busy_hi = k + LAT - 1;
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            junk();
            @(posedge clk);
        end
        if (gap > 0) begin
            @(negedge clk);
            req = 1'b0;
            repeat (gap - 1) @(negedge clk);
        end
    endtask

    // Write accepted, then reset asserted in its second WAIT cycle
    task automatic issue_abort(input logic [31:0] a, input logic [31:0] d);
        int k;
        @(negedge clk);
        req = 1'b1; we = 1'b1; be = 4'hF; addr = a; wdata = d;
        @(posedge clk);
        k = edges + 1;
        busy_lo = k;
        busy_hi = k + 1;
        @(negedge clk);
        junk();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        req = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        req = 1'b0;
        m_rd = 32'd0;
        chk("abort_rdata_cleared", rdata, 32'd0);
        chk("abort_ready_low", {31'd0, ready}, 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          r;
        rst = 1'b1; req = 1'b1; we = 1'b1; be = 4'hF; addr = 32'd0; wdata = 32'hFFFF_FFFF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_ready", {31'd0, ready}, 32'd0);
        chk("reset_err", {31'd0, err}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        rst = 1'b0;
        req = 1'b0;
        mon_en = 1'b1;
        repeat (4) @(negedge clk);

        // Preload the words used by the random phase
        for (int i = 0; i < 16; i++) issue(1'b1, 4'hF, 32'(i * 4), $urandom, 0);

        issue(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 2);
        issue(1'b0, 4'h0, 32'h10, 32'h0, 1);
        issue(1'b1, 4'b0101, 32'h10, 32'h11223344, 0);
        issue(1'b0, 4'h0, 32'h10, 32'h0, 1);
        issue(1'b1, 4'hF, 32'h12, 32'h55555555, 1);
        issue(1'b0, 4'h0, 32'h10, 32'h0, 1);
        issue(1'b0, 4'h0, 32'h400, 32'h0, 1);
        issue(1'b1, 4'h0, 32'h10, 32'hFFFFFFFF, 1);
        issue(1'b0, 4'h0, 32'h10, 32'h0, 1);
        chk("model_be_merge", m_mem[4], 32'hDE22BE44);

        issue(1'b0, 4'h0, 32'h0, 32'h0, 0);
        issue(1'b0, 4'h0, 32'h4, 32'h0, 0);
        issue(1'b0, 4'h0, 32'h8, 32'h0, 2);

        issue_abort(32'h20, 32'hCAFEF00D);
        issue(1'b0, 4'h0, 32'h20, 32'h0, 1);

        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 70)      a = 32'($urandom_range(0, 15)) * 4;
            else if (r < 85) a = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
            else if (r < 95) a = 32'h400 + 32'($urandom_range(0, 255)) * 4;
            else             a = 32'hFFFF_FFF0;
            issue(1'($urandom), 4'($urandom), a, $urandom,
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0);
        end

        @(negedge clk);
        req = 1'b0;
        repeat (LAT + 4) @(negedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
